// File: rtl/noc_reader.sv
// NoC endpoint reader. Flits from a router output port are buffered in a small
// FIFO and drained one per cycle while enabled. Each drained flit has its
// destination, valid bit and per-source sequence number checked. Running counts,
// error pulses and a sticky overflow flag are reported.
module noc_reader #(
    parameter int         WIDTH   = 16,
    parameter int         DEPTH   = 8,
    parameter logic [1:0] MY_DEST = 2'b11
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             write,
    input  logic [WIDTH-1:0] dataIn,
    input  logic             disableme,
    output logic             full,
    output logic             almost_full,
    output logic [15:0]      rx_count,
    output logic [15:0]      err_count,
    output logic [WIDTH-1:0] last_flit,
    output logic             seq_err,
    output logic             dest_err,
    output logic             overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] FULL_LEVEL   = PW'(DEPTH);
    localparam logic [PW-1:0] ALMOST_LEVEL = PW'(DEPTH - 1);
    localparam logic [PW-1:0] PTR_ONE      = PW'(1);

    typedef enum logic {RUN, PAUSE} drainState_t;

    drainState_t      state;
    logic [WIDTH-1:0] fifoMem [DEPTH];
    logic [PW-1:0]    wptr;
    logic [PW-1:0]    rptr;
    logic [PW-1:0]    occupancy;
    logic [9:0]       expectedSeq [4];

    logic             pushEn;
    logic             popEn;
    logic [WIDTH-1:0] headFlit;
    logic [9:0]       headSeq;
    logic [1:0]       headSrc;
    logic [1:0]       headDest;
    logic             headValid;
    logic             seqBad;
    logic             destBad;

    // The extra pointer bit distinguishes a full FIFO from an empty one, so the
    // occupancy is a plain subtraction that wraps correctly.
    assign occupancy   = wptr - rptr;
    assign full        = (occupancy == FULL_LEVEL);
    assign almost_full = (occupancy >= ALMOST_LEVEL);

    // A flit written this edge only becomes visible through wptr after the
    // edge, so it can never be popped in the same cycle it arrives.
    assign pushEn = write && !full;
    assign popEn  = (state == RUN) && (occupancy != '0);

    assign headFlit  = fifoMem[rptr[AW-1:0]];
    assign headSeq   = headFlit[14:5];
    assign headSrc   = headFlit[4:3];
    assign headDest  = headFlit[2:1];
    assign headValid = headFlit[0];
    assign destBad   = (headDest != MY_DEST) || !headValid;
    assign seqBad    = (headSeq != expectedSeq[headSrc]);

    // Storage array; stale contents are harmless because the pointers gate them.
    always_ff @(posedge clk) begin
        if (reset && pushEn) begin
            fifoMem[wptr[AW-1:0]] <= dataIn;
        end
    end

    // Write side: advance on an accepted flit, latch overflow on a dropped one.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wptr     <= '0;
            overflow <= 1'b0;
        end else begin
            if (pushEn) begin
                wptr <= wptr + PTR_ONE;
            end
            if (write && full) begin
                overflow <= 1'b1;
            end
        end
    end

    // Drain control: pause while disableme is high, resume once it drops.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= RUN;
        end else if (disableme) begin
            state <= PAUSE;
        end else begin
            state <= RUN;
        end
    end

    // Read side: pop the head flit, check it, and update counters and table.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rptr      <= '0;
            rx_count  <= '0;
            err_count <= '0;
            last_flit <= '0;
            seq_err   <= 1'b0;
            dest_err  <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                expectedSeq[i] <= '0;
            end
        end else begin
            seq_err  <= 1'b0;
            dest_err <= 1'b0;
            if (popEn) begin
                rptr      <= rptr + PTR_ONE;
                last_flit <= headFlit;
                seq_err   <= seqBad;
                dest_err  <= destBad;
                if (rx_count != 16'hFFFF) begin
                    rx_count <= rx_count + 16'd1;
                end
                if ((seqBad || destBad) && (err_count != 16'hFFFF)) begin
                    err_count <= err_count + 16'd1;
                end
                if (!destBad) begin
                    expectedSeq[headSrc] <= headSeq + 10'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_noc_reader.sv
// Self-checking bench for noc_reader: directed scenarios followed by random
// traffic, all compared against a queue-based behavioural model.
module tb_noc_reader;

    localparam int WIDTH = 16;
    localparam int DEPTH = 8;

    logic             clk;
    logic             reset;
    logic             write;
    logic [WIDTH-1:0] dataIn;
    logic             disableme;
    logic             full;
    logic             almost_full;
    logic [15:0]      rx_count;
    logic [15:0]      err_count;
    logic [WIDTH-1:0] last_flit;
    logic             seq_err;
    logic             dest_err;
    logic             overflow;

    int testCount = 0;
    int failCount = 0;

    // Behavioural model state
    int         mQueue[$];
    int         mExpected[4];
    int         mRx;
    int         mErr;
    int         mLast;
    bit         mSeqErr;
    bit         mDestErr;
    bit         mOverflow;
    bit         mPaused;

    // Writer-side sequence counters per source
    int         wSeq[4];

    noc_reader #(.WIDTH(WIDTH), .DEPTH(DEPTH), .MY_DEST(2'b11)) dut (
        .clk(clk),
        .reset(reset),
        .write(write),
        .dataIn(dataIn),
        .disableme(disableme),
        .full(full),
        .almost_full(almost_full),
        .rx_count(rx_count),
        .err_count(err_count),
        .last_flit(last_flit),
        .seq_err(seq_err),
        .dest_err(dest_err),
        .overflow(overflow)
    );

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic logic [15:0] makeFlit(input int seq, input int src, input int dest, input int valid);
        int v;
        v = ((seq % 1024) * 32) + ((src % 4) * 8) + ((dest % 4) * 2) + (valid % 2);
        return 16'(v);
    endfunction

    // Model of what one rising edge does, from the block's rules.
    task automatic modelEdge(input bit w, input int d, input bit dis, input bit rst);
        int  f;
        int  seq;
        int  src;
        int  dest;
        int  valid;
        bit  wasFull;
        bit  doPop;
        if (!rst) begin
            mQueue.delete();
            for (int i = 0; i < 4; i++) mExpected[i] = 0;
            mRx = 0;
            mErr = 0;
            mLast = 0;
            mSeqErr = 0;
            mDestErr = 0;
            mOverflow = 0;
            mPaused = 0;
        end else begin
            wasFull = (mQueue.size() == DEPTH);
            doPop = !mPaused && (mQueue.size() > 0);
            mSeqErr = 0;
            mDestErr = 0;
            if (doPop) begin
                f = mQueue.pop_front();
                seq = (f / 32) % 1024;
                src = (f / 8) % 4;
                dest = (f / 2) % 4;
                valid = f % 2;
                mLast = f;
                mDestErr = (dest != 3) || (valid == 0);
                mSeqErr = (seq != mExpected[src]);
                if (!mDestErr) mExpected[src] = (seq + 1) % 1024;
                if (mRx < 65535) mRx++;
                if ((mSeqErr || mDestErr) && mErr < 65535) mErr++;
            end
            if (w && !wasFull) mQueue.push_back(d);
            if (w && wasFull) mOverflow = 1;
            mPaused = dis;
        end
    endtask

    // One clock cycle: drive inputs, check level outputs, clock, check results.
    task automatic applyStimulus(input bit w, input logic [15:0] d, input bit dis, input bit rst);
        @(negedge clk);
        write = w;
        dataIn = d;
        disableme = dis;
        reset = rst;
        checkOutput("full", {31'd0, full}, {31'd0, mQueue.size() == DEPTH});
        checkOutput("almost_full", {31'd0, almost_full}, {31'd0, mQueue.size() >= DEPTH - 1});
        @(posedge clk);
        modelEdge(w, int'(d), dis, rst);
        #1;
        checkOutput("rx_count", {16'd0, rx_count}, 32'(mRx));
        checkOutput("err_count", {16'd0, err_count}, 32'(mErr));
        checkOutput("last_flit", {16'd0, last_flit}, 32'(mLast));
        checkOutput("seq_err", {31'd0, seq_err}, {31'd0, mSeqErr});
        checkOutput("dest_err", {31'd0, dest_err}, {31'd0, mDestErr});
        checkOutput("overflow", {31'd0, overflow}, {31'd0, mOverflow});
    endtask

    task automatic doReset(input int cycles);
        for (int i = 0; i < cycles; i++) applyStimulus(1'b1, makeFlit(5, 1, 3, 1), 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) wSeq[i] = 0;
    endtask

    task automatic sendSeq(input int src, input int seq, input int dest, input bit dis);
        applyStimulus(1'b1, makeFlit(seq, src, dest, 1), dis, 1'b1);
    endtask

    task automatic idle(input int cycles, input bit dis);
        for (int i = 0; i < cycles; i++) applyStimulus(1'b0, 16'h0, dis, 1'b1);
    endtask

    initial begin
        int  src;
        int  seq;
        int  dest;
        int  valid;
        bit  w;
        bit  dis;

        reset = 1'b0;
        write = 1'b0;
        dataIn = '0;
        disableme = 1'b0;
        repeat (2) @(posedge clk);

        // Reset, with a write presented during reset that must be ignored
        doReset(2);
        idle(2, 1'b0);

        // Back-to-back stream from src 0, seq 0..19
        for (int s = 0; s < 20; s++) sendSeq(0, s, 3, 1'b0);
        idle(4, 1'b0);
        checkOutput("stream_rx", {16'd0, rx_count}, 32'd20);
        checkOutput("stream_last_seq", {22'd0, last_flit[14:5]}, 32'd19);

        // Paused fill: accept only while not full, then drain
        idle(2, 1'b1);
        for (int i = 0; i < 10; i++) begin
            w = (mQueue.size() < DEPTH);
            applyStimulus(w, makeFlit(20 + i, 0, 3, 1), 1'b1, 1'b1);
        end
        checkOutput("fill_overflow", {31'd0, overflow}, 32'd0);
        idle(12, 1'b0);

        // Forced writes while full are dropped and latch overflow
        idle(2, 1'b1);
        for (int i = 0; i < 8; i++) sendSeq(0, 28 + i, 3, 1'b1);
        sendSeq(0, 99, 3, 1'b1);
        sendSeq(0, 99, 3, 1'b1);
        idle(12, 1'b0);
        checkOutput("overflow_sticky", {31'd0, overflow}, 32'd1);
        doReset(1);

        // src 2 sequence with a gap: 0,1,3,4
        sendSeq(2, 0, 3, 1'b0);
        sendSeq(2, 1, 3, 1'b0);
        sendSeq(2, 3, 3, 1'b0);
        sendSeq(2, 4, 3, 1'b0);
        idle(3, 1'b0);
        checkOutput("gap_err_count", {16'd0, err_count}, 32'd1);

        // Wrong destination and invalid flits, interleaved sources
        sendSeq(0, 0, 3, 1'b0);
        sendSeq(2, 5, 3, 1'b0);
        sendSeq(0, 1, 0, 1'b0);
        sendSeq(2, 6, 3, 1'b0);
        sendSeq(0, 1, 3, 1'b0);
        applyStimulus(1'b1, makeFlit(7, 2, 3, 0), 1'b0, 1'b1);
        sendSeq(2, 7, 3, 1'b0);
        idle(3, 1'b0);
        checkOutput("dest_err_count", {16'd0, err_count}, 32'd3);

        // Reset mid-stream with flits queued, then a clean seq-0 flit
        idle(2, 1'b1);
        for (int i = 0; i < 5; i++) sendSeq(1, 10 + i, 3, 1'b1);
        doReset(1);
        checkOutput("reset_full", {31'd0, full}, 32'd0);
        sendSeq(0, 0, 3, 1'b0);
        idle(3, 1'b0);
        checkOutput("post_reset_err", {16'd0, err_count}, 32'd0);

        // Random traffic
        for (int c = 0; c < 800; c++) begin
            dis = ($urandom_range(0, 3) == 0);
            w = ($urandom_range(0, 2) != 0);
            if (mQueue.size() == DEPTH && $urandom_range(0, 19) != 0) w = 1'b0;
            src = $urandom_range(0, 3);
            seq = ($urandom_range(0, 15) == 0) ? $urandom_range(0, 1023) : wSeq[src];
            dest = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 3) : 3;
            valid = ($urandom_range(0, 14) != 0) ? 1 : 0;
            if (w) wSeq[src] = (seq + 1) % 1024;
            if ($urandom_range(0, 299) == 0) begin
                doReset(1);
            end else begin
                applyStimulus(w, makeFlit(seq, src, dest, valid), dis, 1'b1);
            end
        end
        idle(12, 1'b0);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
